// File: rtl/jt10_adpcmb_dec.sv
// ADPCM-B nibble decoder for the YM2610 delta-T channel: one nibble per advance
// becomes a saturated 16-bit PCM sample while the adaptive step delta is updated.
module jt10_adpcmb_dec #(
  parameter int unsigned DMIN = 127,
  parameter int unsigned DMAX = 24576,
  parameter int unsigned DRST = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        cen55,
  input  logic        adv,
  input  logic        clr,
  input  logic [3:0]  data,
  output logic [15:0] pcm,
  output logic        busy
);

  localparam int unsigned DW = 16;  // pcm, delta and diff width
  localparam int unsigned MW = 19;  // diff product width
  localparam int unsigned SW = 18;  // signed sum width
  localparam int unsigned AW = 22;  // delta multiplier accumulator width

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIFF,
    S_ACC,
    S_MUL,
    S_CLAMP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      nib_q, nib_d;
  logic [DW-1:0]   pcm_q, pcm_d;
  logic [DW-1:0]   delta_q, delta_d;
  logic [DW-1:0]   diff_q, diff_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic            start_c;
  logic [MW-1:0]   diff_full_c;
  logic [SW-1:0]   sum_c;
  logic [DW-1:0]   sat_c;
  logic [7:0]      kmul_c;
  logic [DW-1:0]   prod_sh_c;

  function automatic logic [7:0] k_of(input logic [2:0] m);
    case (m)
      3'd4:    k_of = 8'd77;
      3'd5:    k_of = 8'd102;
      3'd6:    k_of = 8'd128;
      3'd7:    k_of = 8'd153;
      default: k_of = 8'd57;
    endcase
  endfunction

  assign start_c = cen55 & adv & (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= S_IDLE;
    else if (cen) state_q <= state_d;
  end

  // Sequencer: DIFF -> ACC -> eight MUL ticks -> CLAMP; clr always wins.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_c) state_d = S_DIFF;
        S_DIFF:  state_d = S_ACC;
        S_ACC:   state_d = S_MUL;
        S_MUL:   if (cnt_q == 3'd7) state_d = S_CLAMP;
        S_CLAMP: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    nib_d   = nib_q;
    pcm_d   = pcm_q;
    delta_d = delta_q;
    diff_d  = diff_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;

    diff_full_c = MW'({nib_q[2:0], 1'b1}) * MW'(delta_q);
    sum_c = nib_q[3] ? ({{2{pcm_q[15]}}, pcm_q} - {2'b00, diff_q})
                     : ({{2{pcm_q[15]}}, pcm_q} + {2'b00, diff_q});
    // Sum fits in 16 signed bits only when the top three bits agree
    if (sum_c[17:15] == 3'b000 || sum_c[17:15] == 3'b111) sat_c = sum_c[15:0];
    else if (sum_c[17])                                   sat_c = 16'h8000;
    else                                                  sat_c = 16'h7fff;
    kmul_c    = k_of(nib_q[2:0]);
    prod_sh_c = DW'(acc_q >> 6);

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          nib_d  = data;
          busy_d = 1'b1;
        end
      end
      S_DIFF:  diff_d = DW'(diff_full_c >> 3);
      S_ACC: begin
        pcm_d = sat_c;
        acc_d = '0;
        cnt_d = '0;
      end
      S_MUL: begin
        if (kmul_c[cnt_q]) acc_d = acc_q + (AW'(delta_q) << cnt_q);
        cnt_d = cnt_q + 3'd1;
      end
      S_CLAMP: begin
        if (prod_sh_c < DW'(DMIN))      delta_d = DW'(DMIN);
        else if (prod_sh_c > DW'(DMAX)) delta_d = DW'(DMAX);
        else                            delta_d = prod_sh_c;
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase

    if (clr) begin
      pcm_d   = '0;
      delta_d = DW'(DRST);
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q   <= '0;
      pcm_q   <= '0;
      delta_q <= DW'(DRST);
      diff_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (cen) begin
      nib_q   <= nib_d;
      pcm_q   <= pcm_d;
      delta_q <= delta_d;
      diff_q  <= diff_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign pcm  = pcm_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_jt10_adpcmb_dec.sv
// Directed bench for the ADPCM-B nibble decoder: known vectors, tick timing,
// saturation, clr and asynchronous reset behaviour.
module tb_jt10_adpcmb_dec;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        cen55;
  logic        adv;
  logic        clr;
  logic [3:0]  data;
  logic [15:0] pcm;
  logic        busy;

  int checks;
  int errors;
  int m_pcm;
  int m_delta;

  jt10_adpcmb_dec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .cen55 (cen55),
    .adv   (adv),
    .clr   (clr),
    .data  (data),
    .pcm   (pcm),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Independent reference for one nibble using plain integer arithmetic
  task automatic model_step(input logic [3:0] n);
    int kt [8];
    int diff;
    int s;
    int d;
    kt = '{57, 57, 57, 57, 77, 102, 128, 153};
    diff = ((2 * int'(n[2:0]) + 1) * m_delta) / 8;
    s = n[3] ? m_pcm - diff : m_pcm + diff;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    d = (kt[n[2:0]] * m_delta) / 64;
    if (d < 127) d = 127;
    if (d > 24576) d = 24576;
    m_pcm = s;
    m_delta = d;
  endtask

  // One cen tick followed by one cycle with cen low
  task automatic tick(input logic s, input logic a, input logic c, input logic [3:0] d);
    cen = 1'b1; cen55 = s; adv = a; clr = c; data = d;
    @(posedge clk); #1;
    cen = 1'b0; cen55 = 1'b0; adv = 1'b0; clr = 1'b0; data = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic run_nibble(input logic [3:0] n);
    tick(1'b1, 1'b1, 1'b0, n);
    repeat (11) tick(1'b0, 1'b0, 1'b0, 4'h0);
    model_step(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cen = 1'b0; cen55 = 1'b0; adv = 1'b0; clr = 1'b0; data = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_pcm = 0;
    m_delta = 127;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b1; cen55 = 1'b0; adv = 1'b0; clr = 1'b0; data = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pcm !== 16'd0) begin errors++; $display("FAIL reset_pcm: got %0d want 0", $signed(pcm)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dut.delta_q !== 16'd127) begin errors++; $display("FAIL reset_delta: got %0d want 127", dut.delta_q); end
    cen = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t0_busy: got %b want 1", busy); end
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (pcm !== 16'd0) begin errors++; $display("FAIL t1_pcm_old: got %0d want 0", $signed(pcm)); end
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (pcm !== 16'd238) begin errors++; $display("FAIL t2_pcm_new: got %0d want 238", $signed(pcm)); end
    repeat (8) tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t10_busy: got %b want 1", busy); end
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t11_busy: got %b want 0", busy); end
    checks++; if (dut.delta_q !== 16'd303) begin errors++; $display("FAIL nib7_delta: got %0d want 303", dut.delta_q); end
    run_nibble(4'h8);
    checks++; if (pcm !== 16'd201) begin errors++; $display("FAIL nib8_pcm: got %0d want 201", $signed(pcm)); end
    checks++; if (dut.delta_q !== 16'd269) begin errors++; $display("FAIL nib8_delta: got %0d want 269", dut.delta_q); end
  endtask

  task automatic test_min_clamp();
    do_reset();
    run_nibble(4'h0);
    checks++; if (pcm !== 16'd15) begin errors++; $display("FAIL nib0_pcm: got %0d want 15", $signed(pcm)); end
    checks++; if (dut.delta_q !== 16'd127) begin errors++; $display("FAIL nib0_delta_min: got %0d want 127", dut.delta_q); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      run_nibble(4'h7);
      checks++;
      if (pcm !== 16'(m_pcm) || dut.delta_q !== 16'(m_delta)) begin
        errors++;
        $display("FAIL sat_up_step%0d: got pcm %0d delta %0d want pcm %0d delta %0d",
                 i, $signed(pcm), dut.delta_q, m_pcm, m_delta);
      end
    end
    checks++; if (pcm !== 16'h7fff) begin errors++; $display("FAIL sat_pcm_max: got %0d want 32767", $signed(pcm)); end
    checks++; if (dut.delta_q !== 16'd24576) begin errors++; $display("FAIL sat_delta_max: got %0d want 24576", dut.delta_q); end
    for (int i = 0; i < 4; i++) begin
      run_nibble(4'hf);
      checks++;
      if (pcm !== 16'(m_pcm)) begin
        errors++;
        $display("FAIL sat_down_step%0d: got %0d want %0d", i, $signed(pcm), m_pcm);
      end
    end
    checks++; if (pcm !== 16'h8000) begin errors++; $display("FAIL sat_pcm_min: got %0d want -32768", $signed(pcm)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h7);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 4'h0);
    tick(1'b1, 1'b1, 1'b0, 4'hf);
    repeat (6) tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy); end
    checks++; if (pcm !== 16'd238) begin errors++; $display("FAIL b2b_pcm: got %0d want 238", $signed(pcm)); end
    checks++; if (dut.delta_q !== 16'd303) begin errors++; $display("FAIL b2b_delta: got %0d want 303", dut.delta_q); end
    repeat (3) tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (pcm !== 16'd238 || busy !== 1'b0) begin errors++; $display("FAIL b2b_dropped: got pcm %0d busy %b want 238 0", $signed(pcm), busy); end
    tick(1'b1, 1'b0, 1'b0, 4'h7);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (pcm !== 16'd238 || busy !== 1'b0) begin errors++; $display("FAIL noadv: got pcm %0d busy %b want 238 0", $signed(pcm), busy); end
  endtask

  task automatic test_cen_hold();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h7);
    cen = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || pcm !== 16'd0) begin errors++; $display("FAIL cen_hold: got pcm %0d busy %b want 0 1", $signed(pcm), busy); end
    repeat (11) tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (pcm !== 16'd238 || dut.delta_q !== 16'd303) begin errors++; $display("FAIL cen_resume: got pcm %0d delta %0d want 238 303", $signed(pcm), dut.delta_q); end
  endtask

  task automatic test_clr();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h7);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 1'b1, 4'h0);
    checks++; if (pcm !== 16'd0 || busy !== 1'b0 || dut.delta_q !== 16'd127) begin
      errors++; $display("FAIL clr_t6: got pcm %0d busy %b delta %0d want 0 0 127", $signed(pcm), busy, dut.delta_q); end
    repeat (8) tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (dut.delta_q !== 16'd127 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_late_write: got delta %0d busy %b want 127 0", dut.delta_q, busy); end
    tick(1'b1, 1'b1, 1'b1, 4'h7);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_start_busy: got %b want 0", busy); end
    repeat (4) tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (pcm !== 16'd0 || dut.delta_q !== 16'd127) begin
      errors++; $display("FAIL clr_start_pcm: got pcm %0d delta %0d want 0 127", $signed(pcm), dut.delta_q); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h7);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (pcm !== 16'd238) begin errors++; $display("FAIL arst_pre: got %0d want 238", $signed(pcm)); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pcm !== 16'd0 || busy !== 1'b0 || dut.delta_q !== 16'd127) begin
      errors++; $display("FAIL arst_now: got pcm %0d busy %b delta %0d want 0 0 127", $signed(pcm), busy, dut.delta_q); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (10) tick(1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (pcm !== 16'd0 || busy !== 1'b0 || dut.delta_q !== 16'd127) begin
      errors++; $display("FAIL arst_abort: got pcm %0d busy %b delta %0d want 0 0 127", $signed(pcm), busy, dut.delta_q); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_min_clamp();
    test_saturation();
    test_back_to_back();
    test_cen_hold();
    test_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
